if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 52 +++++
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if : bus bundle between the instruction-fetch stage and its
// environment (instruction SRAM port, decode-stage handshake, redirect).
//   inst_sram_en/we/addr/wdata : fetch request to the instruction SRAM
//   inst_sram_rdata            : SRAM read data, one cycle after the request
//   br_taken/br_target         : redirect request from decode
//   ds_allowin                 : decode can accept an instruction this cycle
//   fs_to_ds_valid/fs_pc/fs_inst : instruction presented to decode
// modport master : the fetch stage view
// modport slave  : the SRAM + decode-stage view
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    modport master (
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata,
        input  br_taken,
        input  br_target,
        input  ds_allowin,
        output fs_to_ds_valid,
        output fs_pc,
        output fs_inst
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata,
        output br_taken,
        output br_target,
        output ds_allowin,
        input  fs_to_ds_valid,
        input  fs_pc,
        input  fs_inst
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch pipeline stage.
// Issues the next PC to a synchronous instruction SRAM, holds the fetched
// instruction until decode accepts it, buffers the SRAM word while decode
// stalls, and honours redirects from decode in the same cycle.
// Ports:
//   clk     : single clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : if_stage_if.master (SRAM port, decode handshake, redirect)
// Parameter:
//   RESET_PC : address of the first instruction fetched after reset
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    if_stage_if.master  bus
);

    // fs_pc resets one word before RESET_PC so that the sequential nextpc
    // (fs_pc + 4) points at RESET_PC for the very first fetch.
    localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

    logic        started_q,        started_d;
    logic        fs_valid_q,       fs_valid_d;
    logic [31:0] fs_pc_q,          fs_pc_d;
    logic [31:0] inst_buf_q,       inst_buf_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;

    logic [31:0] nextpc_s;
    logic        fs_allowin_s;
    logic        inst_sram_en_s;
    logic        stall_capture_s;

    // Fetch address, acceptance and SRAM enable
    always_comb begin
        nextpc_s        = bus.br_taken ? bus.br_target : (fs_pc_q + 32'd4);
        // A redirect always frees the stage: the held instruction is discarded.
        fs_allowin_s    = ~fs_valid_q | bus.ds_allowin | bus.br_taken;
        inst_sram_en_s  = started_q & fs_allowin_s;
        // Decode stalls while we hold an unbuffered word: the SRAM output may
        // not survive the stall, so it is captured on this edge.
        stall_capture_s = fs_valid_q & ~bus.ds_allowin & ~bus.br_taken
                          & ~inst_buf_valid_q;
    end

    // Next-state logic for the stage registers
    always_comb begin
        started_d        = 1'b1;
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;
        if (inst_sram_en_s) begin
            fs_valid_d       = 1'b1;
            fs_pc_d          = nextpc_s;
            inst_buf_valid_d = 1'b0;
        end else if (stall_capture_s) begin
            inst_buf_d       = bus.inst_sram_rdata;
            inst_buf_valid_d = 1'b1;
        end else begin
            fs_valid_d       = fs_valid_q;
            inst_buf_valid_d = inst_buf_valid_q;
        end
    end

    // Stage registers with asynchronous reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started_q        <= 1'b0;
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= PC_RESET_VAL;
            inst_buf_q       <= 32'd0;
            inst_buf_valid_q <= 1'b0;
        end else begin
            started_q        <= started_d;
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            inst_buf_q       <= inst_buf_d;
            inst_buf_valid_q <= inst_buf_valid_d;
        end
    end

    // Output drive
    always_comb begin
        bus.inst_sram_en    = inst_sram_en_s;
        bus.inst_sram_we    = 1'b0;
        bus.inst_sram_addr  = nextpc_s;
        bus.inst_sram_wdata = 32'd0;
        bus.fs_to_ds_valid  = fs_valid_q & ~bus.br_taken;
        bus.fs_pc           = fs_pc_q;
        bus.fs_inst         = inst_buf_valid_q ? inst_buf_q : bus.inst_sram_rdata;
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// A per-cycle table drives decode/redirect inputs and lists the expected
// combinational outputs for that cycle; transfers expected by the table are
// pushed to a scoreboard queue and popped by a monitor whenever the DUT
// hands an instruction to decode. The SRAM model returns word = address and
// can scramble its output while no read is issued.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h1c000000;

    typedef struct {
        logic        ds;
        logic        br;
        logic [31:0] tgt;
        logic        scr;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic        chk_inst;
        logic [31:0] e_inst;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        scramble;
    int          n_cmp;
    int          n_bad;
    logic [31:0] sb_q[$];
    vec_t        rows[20];

    if_stage_if bus();

    if_stage #(.RESET_PC(RPC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: word = address, optional garbage while idle
    always @(posedge clk) begin
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= bus.inst_sram_addr;
        else if (scramble)
            bus.inst_sram_rdata <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h @%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each decode transfer must match the next queued PC
    always @(negedge clk) begin
        if (resetn && bus.fs_to_ds_valid && bus.ds_allowin) begin
            if (sb_q.size() == 0) begin
                check("xfer_unexpected", bus.fs_pc, 32'hxxxxxxxx);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                check("xfer_pc", bus.fs_pc, e);
                check("xfer_inst", bus.fs_inst, e);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // ds  br   target         scr  en   addr           val  pc             chk  inst
        rows[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000000, 1'b0, 32'h1bfffffc, 1'b0, 32'h0};
        rows[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000000, 1'b0, 32'h1bfffffc, 1'b0, 32'h0};
        rows[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000004, 1'b1, 32'h1c000000, 1'b1, 32'h1c000000};
        rows[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000008, 1'b1, 32'h1c000004, 1'b1, 32'h1c000004};
        rows[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c00000c, 1'b1, 32'h1c000008, 1'b1, 32'h1c000008};
        rows[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c00000c, 1'b1, 32'h1c000008, 1'b1, 32'h1c000008};
        rows[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c00000c, 1'b1, 32'h1c000008, 1'b1, 32'h1c000008};
        rows[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c00000c, 1'b1, 32'h1c000008, 1'b1, 32'h1c000008};
        rows[8]  = '{1'b1, 1'b1, 32'h1c000100, 1'b0, 1'b1, 32'h1c000100, 1'b0, 32'h1c00000c, 1'b1, 32'h1c00000c};
        rows[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000104, 1'b1, 32'h1c000100, 1'b1, 32'h1c000100};
        rows[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c000108, 1'b1, 32'h1c000104, 1'b1, 32'h1c000104};
        rows[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c000108, 1'b1, 32'h1c000104, 1'b1, 32'h1c000104};
        rows[12] = '{1'b0, 1'b1, 32'h1c000040, 1'b1, 1'b1, 32'h1c000040, 1'b0, 32'h1c000104, 1'b1, 32'h1c000104};
        rows[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000044, 1'b1, 32'h1c000040, 1'b1, 32'h1c000040};
        rows[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000044, 1'b1, 32'h1c000040, 1'b1, 32'h1c000040};
        rows[15] = '{1'b1, 1'b1, 32'hfffffffc, 1'b0, 1'b1, 32'hfffffffc, 1'b0, 32'h1c000044, 1'b1, 32'h1c000044};
        rows[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00000000, 1'b1, 32'hfffffffc, 1'b1, 32'hfffffffc};
        rows[17] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00000004, 1'b1, 32'h00000000, 1'b1, 32'h00000000};
        rows[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00000008, 1'b1, 32'h00000004, 1'b1, 32'h00000004};
        rows[19] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00000008, 1'b1, 32'h00000004, 1'b1, 32'h00000004};

        resetn              = 1'b0;
        scramble            = 1'b0;
        bus.ds_allowin      = 1'b1;
        bus.br_taken        = 1'b0;
        bus.br_target       = 32'd0;
        bus.inst_sram_rdata = 32'd0;

        // Reset-state outputs
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en",    {31'd0, bus.inst_sram_en},   32'd0);
        check("rst_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
        check("rst_pc",    bus.fs_pc,                   RPC - 32'd4);
        check("rst_addr",  bus.inst_sram_addr,          RPC);
        check("rst_we",    {31'd0, bus.inst_sram_we},   32'd0);
        check("rst_wdata", bus.inst_sram_wdata,         32'd0);

        // Table-driven run: release reset with row 0
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            resetn         = 1'b1;
            bus.ds_allowin = rows[i].ds;
            bus.br_taken   = rows[i].br;
            bus.br_target  = rows[i].tgt;
            scramble       = rows[i].scr;
            if (rows[i].e_val && !rows[i].br && rows[i].ds)
                sb_q.push_back(rows[i].e_pc);
            @(negedge clk);
            check($sformatf("r%0d_en", i),    {31'd0, bus.inst_sram_en},   {31'd0, rows[i].e_en});
            check($sformatf("r%0d_addr", i),  bus.inst_sram_addr,          rows[i].e_addr);
            check($sformatf("r%0d_valid", i), {31'd0, bus.fs_to_ds_valid}, {31'd0, rows[i].e_val});
            check($sformatf("r%0d_pc", i),    bus.fs_pc,                   rows[i].e_pc);
            if (rows[i].chk_inst)
                check($sformatf("r%0d_inst", i), bus.fs_inst, rows[i].e_inst);
        end

        // Asynchronous reset in the middle of a stall
        #1;
        resetn = 1'b0;
        #1;
        check("mid_rst_en",    {31'd0, bus.inst_sram_en},   32'd0);
        check("mid_rst_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
        check("mid_rst_pc",    bus.fs_pc,                   RPC - 32'd4);
        check("mid_rst_addr",  bus.inst_sram_addr,          RPC);

        // Restart: first instruction two edges after release
        @(posedge clk);
        #2;
        resetn         = 1'b1;
        bus.ds_allowin = 1'b1;
        @(negedge clk);
        check("re_en0", {31'd0, bus.inst_sram_en}, 32'd0);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("re_en1",   {31'd0, bus.inst_sram_en}, 32'd1);
        check("re_addr1", bus.inst_sram_addr,        RPC);
        @(posedge clk);
        #2;
        sb_q.push_back(RPC);
        @(negedge clk);
        check("re_valid", {31'd0, bus.fs_to_ds_valid}, 32'd1);
        check("re_pc",    bus.fs_pc,                   RPC);
        @(posedge clk);
        #2;
        sb_q.push_back(RPC + 32'd4);
        @(negedge clk);
        @(posedge clk);
        #2;
        bus.ds_allowin = 1'b0;
        @(negedge clk);
        check("sb_left", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
